lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator for the core's data memory port: it accepts one RV32I load or store request from the MEM stage and sequences word-addressed, byte-enabled accesses on the data memory. The memory side has a word address, a 4-bit byte write enable, combinational read and synchronous write. The block generates byte lanes and shifts store data. It sign- or zero-extends load data and, when enabled, splits word-crossing accesses into two memory accesses.

## Interface
Parameters:
- none; all widths are fixed by RV32I.

Ports:
- clk  in  1  core clock; all state changes on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse; load data / completion valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid; illegal funct3 or disallowed misalignment
- mem_addr  out  30  word address [31:2]
- mem_write_en  out  4  byte write enables
- mem_in_data  out  32  lane-aligned store data
- mem_out_data  in  32  combinational read data of mem_addr

## Operation
- States: IDLE, ACC1, ACC2, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register addr, wdata, we and funct3, and compute the width mask: B=0001, H=0011, W=1111.
  - Illegal funct3 (011, 110, 111; 100/101 with req_we=1): next state RESP with resp_err=1, no memory access.
- ACC1:
  - mem_addr = addr[31:2], off = addr[1:0].
  - Store: mem_write_en = (mask<<off)[3:0], mem_in_data = wdata<<(8*off).
  - Load: mem_write_en = 0 and mem_out_data is captured as lo.
  - If the access crosses a word boundary (off + size > 4), go to ACC2; otherwise go to RESP.
- ACC2:
  - mem_addr = addr[31:2]+1 in 30-bit arithmetic; 0x3FFFFFFF wraps to 0.
  - Store: mem_write_en = mask>>(4-off), mem_in_data = wdata>>(8*(4-off)).
  - Load: capture hi.
  - Next state RESP.
- Load result:
  - raw = {hi,lo}>>(8*off); hi=0 when there is no second access.
  - B/H results sign-extend from bit 7/15; BU/HU zero-extend.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- mem_write_en is 0 in every state except a store's ACC1/ACC2.
- Misaligned access that stays inside one word (H at off=1) is always a single access.

## Timing
- Accept at cycle 0. Responses:
  - Aligned or in-word: resp_valid at cycle 2.
  - Split: resp_valid at cycle 3.
  - Error: resp_valid at cycle 1.
- Store bytes are committed on the posedge that ends ACC1 (and ACC2).
- No response backpressure; the consumer must take resp in its valid cycle.
- Next accept is no earlier than the cycle after RESP. req_ready is low in ACC1, ACC2 and RESP.
- Reset:
  - While rst_n=0 at a posedge: state→IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_en=0, mem_addr=0, mem_in_data=0.
  - req_ready=0 while rst_n=0.
  - Reset during ACC1/ACC2 aborts the operation: a first-half store already committed stays, the second half is never written, and no response is issued.

## Configuration
- LSU_MISALIGNED_EN defined: word-crossing accesses are split as above.
- LSU_MISALIGNED_EN undefined: any non-naturally-aligned H/HU/W (addr[0]≠0 for half, addr[1:0]≠0 for word) goes IDLE→RESP with resp_err=1, no memory write, and resp at cycle 1. ACC2 logic is removed.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants (LSU_F3_B, _H, _W, _BU, _HU)
  - state enum
  - width-mask function
- One sub-module, lsu_lane_align: combinational lane logic covering store shift/mask for both halves and load merge/extend. The FSM, registers and handshake stay in lsu_mem_master.

## Test plan
- Aligned store then load: SW 0x12345678 @0x100, then LW @0x100 → mem_write_en=1111 on mem_addr 0x40; resp_rdata=0x12345678 at cycle 2.
- Byte store and signed/unsigned loads: SB 0xAB @0x103 → mem_write_en=1000. Then LB @0x103 → 0xFFFFFFAB; LBU → 0x000000AB.
- Split store (LSU_MISALIGNED_EN): SW 0xDDCCBBAA @0x102 → ACC1 word 0x40 en=1100 data 0xBBAA0000; ACC2 word 0x41 en=0011 data 0x0000DDCC. LW @0x102 returns 0xDDCCBBAA at cycle 3.
- Misaligned without macro: SH @0x001 → resp_err=1 at cycle 1, mem_write_en stays 0000.
- Illegal funct3=011 load → resp_err=1, resp_rdata=0, cycle 1, no memory access.
- Reset in ACC2 of split store @0xFFFFFFFE: second half to word 0x00000000 never written; state IDLE next cycle; req_ready=1 after rst_n rises.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RV32I load/store funct3 codes, FSM state encoding
// and the width/alignment helpers used by lsu_mem_master.
package lsu_pkg;

   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC1 = 2'd1,
      S_ACC2 = 2'd2,
      S_RESP = 2'd3
   } lsu_state_e;

   function automatic logic [3:0] lsu_width_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Unsigned variants have no store form.
   function automatic logic lsu_f3_illegal(input logic [2:0] f3, input logic we);
      case (f3)
         LSU_F3_B, LSU_F3_H, LSU_F3_W: return 1'b0;
         LSU_F3_BU, LSU_F3_HU:         return we;
         default:                      return 1'b1;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
   endfunction

   function automatic logic lsu_crosses(input logic [3:0] mask, input logic [1:0] off);
      logic [3:0] size;
      size = mask[3] ? 4'd4 : (mask[1] ? 4'd2 : 4'd1);
      return ({2'b00, off} + size) > 4'd4;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store enable/data placement for the first
// and second word of an access, and load merge plus sign/zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [3:0]  mask_i,
   input  logic [2:0]  funct3_i,
   input  logic        second_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [3:0]  st_en_o,
   output logic [31:0] st_data_o,
   output logic [31:0] ld_data_o
);

   logic [5:0]  sh_lo;
   logic [5:0]  sh_hi;
   logic [31:0] raw;

   assign sh_lo = {1'b0, off_i, 3'b000};
   assign sh_hi = 6'd32 - sh_lo;

   // Second word takes the bytes that spilled past lane 3.
   assign st_en_o   = second_i ? (mask_i >> (3'd4 - {1'b0, off_i}))
                               : 4'(({4'b0000, mask_i}) << off_i);
   assign st_data_o = second_i ? (wdata_i >> sh_hi) : (wdata_i << sh_lo);

   assign raw = 32'(({hi_i, lo_i}) >> sh_lo);

   always_comb begin
      ld_data_o = raw;
      case (funct3_i)
         LSU_F3_B:  ld_data_o = {{24{raw[7]}}, raw[7:0]};
         LSU_F3_H:  ld_data_o = {{16{raw[15]}}, raw[15:0]};
         LSU_F3_BU: ld_data_o = {24'd0, raw[7:0]};
         LSU_F3_HU: ld_data_o = {16'd0, raw[15:0]};
         default:   ld_data_o = raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data memory port. Define LSU_MISALIGNED_EN to
// split word-crossing accesses; otherwise misaligned H/W requests return an error.
module lsu_mem_master
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_write_en,
   output logic [31:0] mem_in_data,
   input  logic [31:0] mem_out_data
);

   lsu_state_e  state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [3:0]  mask_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic        req_bad;
   logic        second;
   logic        crosses;
   logic [31:0] lo_sel;
   logic [31:0] hi_sel;
   logic [3:0]  st_en;
   logic [31:0] st_data;
   logic [31:0] ld_data;

   always_comb begin
      req_bad = lsu_f3_illegal(req_funct3, req_we);
`ifndef LSU_MISALIGNED_EN
      if (lsu_misaligned(req_funct3, req_addr[1:0])) req_bad = 1'b1;
`endif
   end

`ifdef LSU_MISALIGNED_EN
   logic [31:0] lo_q;
   assign second  = (state_q == S_ACC2);
   assign crosses = lsu_crosses(mask_q, addr_q[1:0]);
   assign lo_sel  = second ? lo_q : mem_out_data;
   assign hi_sel  = second ? mem_out_data : 32'd0;
`else
   assign second  = 1'b0;
   assign crosses = 1'b0;
   assign lo_sel  = mem_out_data;
   assign hi_sel  = 32'd0;
`endif

   lsu_lane_align u_align (
      .off_i     (addr_q[1:0]),
      .mask_i    (mask_q),
      .funct3_i  (f3_q),
      .second_i  (second),
      .wdata_i   (wdata_q),
      .lo_i      (lo_sel),
      .hi_i      (hi_sel),
      .st_en_o   (st_en),
      .st_data_o (st_data),
      .ld_data_o (ld_data)
   );

   // Enables are gated by rst_n so a reset mid-access never commits a byte.
   always_comb begin
      mem_addr     = 30'd0;
      mem_write_en = 4'b0000;
      mem_in_data  = 32'd0;
      if (rst_n && (state_q == S_ACC1 || state_q == S_ACC2)) begin
         mem_addr = second ? (addr_q[31:2] + 30'd1) : addr_q[31:2];
         if (we_q) begin
            mem_write_en = st_en;
            mem_in_data  = st_data;
         end
      end
   end

   assign req_ready  = rst_n && (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && req_valid) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         we_q    <= req_we;
         f3_q    <= req_funct3;
         mask_q  <= lsu_width_mask(req_funct3);
      end
`ifdef LSU_MISALIGNED_EN
      if (state_q == S_ACC1) lo_q <= mem_out_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_bad) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'd0;
                  end else begin
                     state_q <= S_ACC1;
                  end
               end
            end
            S_ACC1: begin
               if (crosses) begin
                  state_q <= S_ACC2;
               end else begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= we_q ? 32'd0 : ld_data;
               end
            end
`ifdef LSU_MISALIGNED_EN
            S_ACC2: begin
               state_q      <= S_RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= we_q ? 32'd0 : ld_data;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-enabled word memory model;
// split-access steps follow LSU_MISALIGNED_EN.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [29:0] mem_addr;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_in_data;
   logic [31:0] mem_out_data;

   logic [31:0] mem [0:255];
   logic        w0_written = 1'b0;
   int          tests = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   lsu_mem_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_in_data  (mem_in_data),
      .mem_out_data (mem_out_data)
   );

   assign mem_out_data = mem[mem_addr[7:0]];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_write_en[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_in_data[8*b +: 8];
      if (mem_write_en != 4'b0000 && mem_addr == 30'd0) w0_written <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns 1 ns into the cycle after acceptance (first access cycle).
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      int n = 0;
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      check("ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      step();
      req_valid  = 1'b0;
   endtask

   task automatic load_expect(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] exp);
      issue(1'b0, f3, addr, 32'd0);
      check({tag, "_we"}, {28'd0, mem_write_en}, 32'd0);
      step();
      check({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_data"}, resp_rdata, exp);
      step();
   endtask

   task automatic err_expect(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
      issue(we, f3, addr, 32'hFFFF_FFFF);
      check({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_err"}, {31'd0, resp_err}, 32'd1);
      check({tag, "_data"}, resp_rdata, 32'd0);
      check({tag, "_we"}, {28'd0, mem_write_en}, 32'd0);
      step();
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      step(); step(); step();
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_vld", {31'd0, resp_valid}, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_we", {28'd0, mem_write_en}, 32'd0);
      check("rst_addr", {2'd0, mem_addr}, 32'd0);
      check("rst_wdata", mem_in_data, 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_ready", {31'd0, req_ready}, 32'd1);

      // Aligned word store then load
      issue(1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678);
      check("sw_addr", {2'd0, mem_addr}, 32'h40);
      check("sw_en", {28'd0, mem_write_en}, 32'hF);
      check("sw_data", mem_in_data, 32'h1234_5678);
      check("sw_busy", {31'd0, req_ready}, 32'd0);
      check("sw_early", {31'd0, resp_valid}, 32'd0);
      step();
      check("sw_vld", {31'd0, resp_valid}, 32'd1);
      check("sw_err", {31'd0, resp_err}, 32'd0);
      check("sw_rdata", resp_rdata, 32'd0);
      check("sw_resp_we", {28'd0, mem_write_en}, 32'd0);
      step();
      check("sw_pulse", {31'd0, resp_valid}, 32'd0);
      load_expect("lw", 3'b010, 32'h0000_0100, 32'h1234_5678);

      // Byte store into lane 3, then extended loads
      issue(1'b1, 3'b000, 32'h0000_0103, 32'hFFFF_FFAB);
      check("sb_en", {28'd0, mem_write_en}, 32'h8);
      check("sb_data", mem_in_data, 32'hAB00_0000);
      step(); step();
      load_expect("lb", 3'b000, 32'h0000_0103, 32'hFFFF_FFAB);
      load_expect("lbu", 3'b100, 32'h0000_0103, 32'h0000_00AB);
      load_expect("lh", 3'b001, 32'h0000_0102, 32'hFFFF_AB34);
      load_expect("lhu", 3'b101, 32'h0000_0102, 32'h0000_AB34);

      // Illegal funct3 codes
      err_expect("f3_011", 1'b0, 3'b011, 32'h0000_0100);
      err_expect("f3_110", 1'b0, 3'b110, 32'h0000_0100);
      err_expect("sbu", 1'b1, 3'b100, 32'h0000_0100);

      // Reset during a store's first access blocks the write
      issue(1'b1, 3'b010, 32'h0000_0020, 32'h0000_0000);
      step(); step();
      issue(1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D);
      rst_n = 1'b0;
      #1;
      check("abort1_we", {28'd0, mem_write_en}, 32'd0);
      step();
      check("abort1_vld", {31'd0, resp_valid}, 32'd0);
      check("abort1_ready_low", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("abort1_ready", {31'd0, req_ready}, 32'd1);
      load_expect("abort1_lw", 3'b010, 32'h0000_0020, 32'h0000_0000);

`ifdef LSU_MISALIGNED_EN
      load_expect("lh_inword", 3'b001, 32'h0000_0101, 32'h0000_3456);

      // Word store crossing into word 0x41
      issue(1'b1, 3'b010, 32'h0000_0102, 32'hDDCC_BBAA);
      check("ssw1_addr", {2'd0, mem_addr}, 32'h40);
      check("ssw1_en", {28'd0, mem_write_en}, 32'hC);
      check("ssw1_data", mem_in_data, 32'hBBAA_0000);
      step();
      check("ssw2_addr", {2'd0, mem_addr}, 32'h41);
      check("ssw2_en", {28'd0, mem_write_en}, 32'h3);
      check("ssw2_data", mem_in_data, 32'h0000_DDCC);
      check("ssw2_early", {31'd0, resp_valid}, 32'd0);
      step();
      check("ssw_vld", {31'd0, resp_valid}, 32'd1);
      step();

      issue(1'b0, 3'b010, 32'h0000_0102, 32'd0);
      step();
      check("slw_early", {31'd0, resp_valid}, 32'd0);
      step();
      check("slw_vld", {31'd0, resp_valid}, 32'd1);
      check("slw_data", resp_rdata, 32'hDDCC_BBAA);
      step();

      issue(1'b0, 3'b001, 32'h0000_0103, 32'd0);
      step(); step();
      check("slh_vld", {31'd0, resp_valid}, 32'd1);
      check("slh_data", resp_rdata, 32'hFFFF_CCBB);
      step();

      // Reset in the second access of a store that wraps to word 0
      issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
      check("wrap1_addr", {2'd0, mem_addr}, 32'h3FFF_FFFF);
      check("wrap1_en", {28'd0, mem_write_en}, 32'hC);
      step();
      check("wrap2_addr", {2'd0, mem_addr}, 32'd0);
      check("wrap2_en", {28'd0, mem_write_en}, 32'h3);
      rst_n = 1'b0;
      #1;
      check("wrap_rst_en", {28'd0, mem_write_en}, 32'd0);
      step();
      check("wrap_rst_vld", {31'd0, resp_valid}, 32'd0);
      check("wrap_rst_ready", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("wrap_ready", {31'd0, req_ready}, 32'd1);
      step();
      check("wrap_vld", {31'd0, resp_valid}, 32'd0);
      check("wrap_w0", {31'd0, w0_written}, 32'd0);
      check("wrap_first_half", {16'd0, mem[8'hFF][31:16]}, 32'h0000_3344);
`else
      err_expect("sh_mis", 1'b1, 3'b001, 32'h0000_0001);
      err_expect("lh_mis", 1'b0, 3'b001, 32'h0000_0101);
      err_expect("lw_mis", 1'b0, 3'b010, 32'h0000_0102);
      load_expect("lw_after_err", 3'b010, 32'h0000_0100, 32'hAB34_5678);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
